arb_req_ctrl: RTL

//   Upstream request controller for the 3-way arbiter. Each client posts a transfer request
//   (length in beats) over valid/ready; the block holds one pending slot per client and drives
//   the arbiter request vector r. It watches the arbiter grant vector g, runs the granted

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_req_slot.sv | 50 +++++
 rtl/arb_req_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the arbiter request controller.
package arb_pkg;

   localparam int unsigned N_CLIENTS = 3;
   localparam int unsigned LEN_W     = 4;
   localparam int unsigned OWNER_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/arb_req_slot.sv
// One client's pending slot: a pending flag and latched length behind valid/ready.
module arb_req_slot #(
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             clear_i,
   output logic             ready_o,
   output logic             pending_o,
   output logic             pending_d_o,
   output logic [LEN_W-1:0] len_o
);

   logic             pending_q, pending_d;
   logic             ready_q;
   logic [LEN_W-1:0] len_q, len_d;

   // Accept only into an empty slot; the owner's slot is cleared on its last beat
   always_comb begin
      pending_d = pending_q;
      len_d     = len_q;
      if (clear_i) begin
         pending_d = 1'b0;
      end else if (valid_i && !pending_q) begin
         pending_d = 1'b1;
         len_d     = len_i;
      end
   end

   // Slot registers; ready is registered from the next pending value
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= 1'b0;
         len_q     <= '0;
         ready_q   <= 1'b1;
      end else begin
         pending_q <= pending_d;
         len_q     <= len_d;
         ready_q   <= ~pending_d;
      end
   end

   assign ready_o     = ready_q;
   assign pending_o   = pending_q;
   assign pending_d_o = pending_d;
   assign len_o       = len_q;

endmodule

// File: rtl/arb_req_ctrl.sv
// Request controller for the 3-way arbiter: holds per-client requests, drives r,
// runs the granted client's transfer beat-by-beat and releases it afterwards.
module arb_req_ctrl #(
   parameter int unsigned N     = arb_pkg::N_CLIENTS,
   parameter int unsigned LEN_W = arb_pkg::LEN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req_valid,
   input  logic [N*LEN_W-1:0] req_len,
   output logic [N-1:0]       req_ready,
   output logic [N-1:0]       r,
   input  logic [N-1:0]       g,
   output logic               beat,
   output logic [1:0]         owner,
   output logic               busy,
   output logic [N-1:0]       done,
   output logic               err
);

   localparam int unsigned OWN_W = arb_pkg::OWNER_W;

   arb_pkg::state_t  state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [OWN_W-1:0] owner_q, owner_d;
   logic             err_q, err_d;
   logic [N-1:0]     r_q, r_d;
   logic             beat_q, beat_d;
   logic [N-1:0]     done_q, done_d;

   logic [N-1:0]     pending, pend_nxt, clear_c, slot_ready;
   logic [LEN_W-1:0] slot_len [N];
   logic             g_onehot;
   logic [OWN_W-1:0] g_idx;

   // Per-client pending slots
   for (genvar i = 0; i < N; i++) begin : g_slot
      arb_req_slot #(.LEN_W(LEN_W)) u_slot (
         .clk         (clk),
         .rst         (rst),
         .valid_i     (req_valid[i]),
         .len_i       (req_len[i*LEN_W +: LEN_W]),
         .clear_i     (clear_c[i]),
         .ready_o     (slot_ready[i]),
         .pending_o   (pending[i]),
         .pending_d_o (pend_nxt[i]),
         .len_o       (slot_len[i])
      );
   end

   // Next-state logic: grant check in IDLE, beat counting in BUSY, one release cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      err_d    = err_q;
      clear_c  = '0;
      g_onehot = (g != '0) && ((g & (g - N'(1))) == '0);
      g_idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (g[i]) g_idx = OWN_W'(i);
      end

      case (state_q)
         arb_pkg::ST_IDLE: begin
            if (g != '0) begin
               if (g_onehot && pending[g_idx]) begin
                  state_d = arb_pkg::ST_BUSY;
                  owner_d = g_idx;
                  cnt_d   = (slot_len[g_idx] == '0) ? LEN_W'(1) : slot_len[g_idx];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         arb_pkg::ST_BUSY: begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
               clear_c[owner_q] = 1'b1;
               state_d          = arb_pkg::ST_RELEASE;
            end
         end
         arb_pkg::ST_RELEASE: state_d = arb_pkg::ST_IDLE;
         default:             state_d = arb_pkg::ST_IDLE;
      endcase

      // Outputs are registered from the next-state view so they line up with the state
      r_d    = pend_nxt & {N{state_d == arb_pkg::ST_IDLE}};
      beat_d = (state_d == arb_pkg::ST_BUSY);
      done_d = (beat_d && (cnt_d == LEN_W'(1))) ? (N'(1) << owner_d) : '0;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= arb_pkg::ST_IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
         r_q     <= '0;
         beat_q  <= 1'b0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         err_q   <= err_d;
         r_q     <= r_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
      end
   end

   assign req_ready = slot_ready;
   assign r         = r_q;
   assign beat      = beat_q;
   assign busy      = beat_q;
   assign owner     = owner_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
